// File: rtl/wb_port_arbiter.sv
`default_nettype none
// wb_port_arbiter: shares the register-file write port between WB and a buffered long-latency unit,
// with a starvation counter that forces a drain by stalling the pipeline.
module wb_port_arbiter #(
  parameter int DBITS        = 32,
  parameter int REGNOBITS    = 5,
  parameter int REGWORDS     = 32,
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CNTBITS     = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pipe_valid,
  input  logic                 pipe_wr_reg,
  input  logic [REGNOBITS-1:0] pipe_wregno,
  input  logic [DBITS-1:0]     pipe_regval,
  output logic                 pipe_stall,
  input  logic                 ll_valid,
  input  logic [REGNOBITS-1:0] ll_wregno,
  input  logic [DBITS-1:0]     ll_regval,
  output logic                 ll_ready,
  output logic                 wr_reg,
  output logic [REGNOBITS-1:0] wregno,
  output logic [DBITS-1:0]     regval,
  output logic [REGWORDS-1:0]  pend_mask,
  output logic [CNTBITS-1:0]   starve_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [REGNOBITS-1:0] mem_regno_q [FIFO_DEPTH];
  logic [DBITS-1:0]     mem_val_q   [FIFO_DEPTH];
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic [CNTBITS-1:0]   starve_q, starve_d;

  logic pipe_req, ll_req, full, force_drain, push, grant_ll, grant_pipe;
  logic [REGNOBITS-1:0] head_regno;
  logic [DBITS-1:0]     head_val;

  assign pipe_req    = pipe_valid & pipe_wr_reg;
  assign ll_req      = (count_q != '0);
  assign full        = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign force_drain = ll_req && (starve_q == CNTBITS'(STARVE_LIMIT));
  assign ll_ready    = !reset && !full;
  assign push        = ll_valid && ll_ready;
  assign head_regno  = mem_regno_q[rd_ptr_q];
  assign head_val    = mem_val_q[rd_ptr_q];
  assign starve_cnt  = starve_q;

  // Grants are suppressed during reset so no write escapes in the reset cycle.
  always_comb begin
    grant_ll   = 1'b0;
    grant_pipe = 1'b0;
    wr_reg     = 1'b0;
    wregno     = '0;
    regval     = '0;
    pipe_stall = 1'b0;
    if (!reset) begin
      if (ll_req && (!pipe_req || force_drain)) begin
        grant_ll   = 1'b1;
        wregno     = head_regno;
        regval     = head_val;
        wr_reg     = (head_regno != '0);
        pipe_stall = pipe_req;
      end else if (pipe_req) begin
        grant_pipe = 1'b1;
        wregno     = pipe_wregno;
        regval     = pipe_regval;
        wr_reg     = (pipe_wregno != '0);
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + AW'(grant_ll);
    wr_ptr_d = wr_ptr_q + AW'(push);
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(grant_ll);
    starve_d = starve_q;
    if (!ll_req || grant_ll) begin
      starve_d = '0;
    end else if (grant_pipe && (starve_q != CNTBITS'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    logic [AW-1:0] offs;
    offs      = '0;
    pend_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offs = AW'(i) - rd_ptr_q;
      if (((AW + 1)'(offs) < count_q) && (mem_regno_q[i] != '0)) begin
        pend_mask[mem_regno_q[i]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Storage needs no reset: occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_regno_q[wr_ptr_q] <= ll_wregno;
      mem_val_q[wr_ptr_q]   <= ll_regval;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// Directed bench for wb_port_arbiter with hand-computed expectations (default parameters).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pipe_valid, pipe_wr_reg;
  logic [4:0]  pipe_wregno;
  logic [31:0] pipe_regval;
  logic        pipe_stall;
  logic        ll_valid;
  logic [4:0]  ll_wregno;
  logic [31:0] ll_regval;
  logic        ll_ready;
  logic        wr_reg;
  logic [4:0]  wregno;
  logic [31:0] regval;
  logic [31:0] pend_mask;
  logic [2:0]  starve_cnt;

  int total = 0;
  int bad   = 0;

  wb_port_arbiter dut (
    .clk(clk), .reset(reset),
    .pipe_valid(pipe_valid), .pipe_wr_reg(pipe_wr_reg),
    .pipe_wregno(pipe_wregno), .pipe_regval(pipe_regval), .pipe_stall(pipe_stall),
    .ll_valid(ll_valid), .ll_wregno(ll_wregno), .ll_regval(ll_regval), .ll_ready(ll_ready),
    .wr_reg(wr_reg), .wregno(wregno), .regval(regval),
    .pend_mask(pend_mask), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                     input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    pipe_valid  = pv;
    pipe_wr_reg = pv;
    pipe_wregno = pr;
    pipe_regval = pd;
    ll_valid    = lv;
    ll_wregno   = lr;
    ll_regval   = ld;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drv(1, 5'd3, 32'h33, 0, 0, 0);
    cyc(); cyc();
    chk("rst_ll_ready", ll_ready, 0);
    chk("rst_wr_reg", wr_reg, 0);
    chk("rst_stall", pipe_stall, 0);
    chk("rst_wregno", wregno, 0);
    chk("rst_regval", regval, 0);
    cyc(); reset = 1'b0; drv(0, 0, 0, 0, 0, 0);
    chk("post_rst_ready", ll_ready, 1);
    chk("post_rst_pend", pend_mask, 0);
    chk("post_rst_starve", starve_cnt, 0);
    chk("post_rst_wr", wr_reg, 0);

    // Idle port: LL result written the cycle after acceptance
    cyc(); drv(0, 0, 0, 1, 5'd5, 32'hDEAD);
    chk("idle_c0_wr", wr_reg, 0);
    chk("idle_c0_pend", pend_mask, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("idle_c1_wr", wr_reg, 1);
    chk("idle_c1_wregno", wregno, 5);
    chk("idle_c1_regval", regval, 32'hDEAD);
    chk("idle_c1_pend", pend_mask, 32'h20);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("idle_c2_pend", pend_mask, 0);
    chk("idle_c2_wr", wr_reg, 0);

    // Starvation: r7 buffered while the pipe writes every cycle
    cyc(); drv(1, 5'd1, 32'h101, 1, 5'd7, 32'h77);
    chk("stv_r1_wregno", wregno, 1);
    chk("stv_r1_stall", pipe_stall, 0);
    for (int k = 2; k <= 5; k++) begin
      cyc(); drv(1, 5'(k), 32'h100 + k, 0, 0, 0);
      chk("stv_pipe_wregno", wregno, k);
      chk("stv_pipe_cnt", starve_cnt, k - 2);
      chk("stv_pipe_stall", pipe_stall, 0);
      chk("stv_pipe_pend", pend_mask, 32'h80);
    end
    cyc(); drv(1, 5'd6, 32'h106, 0, 0, 0);
    chk("stv_force_cnt", starve_cnt, 4);
    chk("stv_force_wregno", wregno, 7);
    chk("stv_force_regval", regval, 32'h77);
    chk("stv_force_stall", pipe_stall, 1);
    chk("stv_force_wr", wr_reg, 1);
    cyc(); drv(1, 5'd6, 32'h106, 0, 0, 0);
    chk("stv_resume_wregno", wregno, 6);
    chk("stv_resume_stall", pipe_stall, 0);
    chk("stv_resume_cnt", starve_cnt, 0);
    chk("stv_resume_pend", pend_mask, 0);

    // Full FIFO under continuous pipe traffic
    cyc(); drv(1, 5'd10, 32'hA0, 1, 5'd11, 32'hB1);
    chk("full_f0_ready", ll_ready, 1);
    cyc(); drv(1, 5'd12, 32'hA2, 1, 5'd13, 32'hB3);
    chk("full_f1_ready", ll_ready, 1);
    chk("full_f1_wregno", wregno, 12);
    chk("full_f1_cnt", starve_cnt, 0);
    cyc(); drv(1, 5'd14, 32'hA4, 1, 5'd15, 32'hB5);
    chk("full_f2_ready", ll_ready, 0);
    chk("full_f2_pend", pend_mask, 32'h0000_2800);
    chk("full_f2_cnt", starve_cnt, 1);
    cyc(); drv(1, 5'd16, 32'hA6, 1, 5'd15, 32'hB5);
    chk("full_f3_ready", ll_ready, 0);
    chk("full_f3_cnt", starve_cnt, 2);
    cyc(); drv(1, 5'd17, 32'hA7, 1, 5'd15, 32'hB5);
    chk("full_f4_ready", ll_ready, 0);
    chk("full_f4_cnt", starve_cnt, 3);
    cyc(); drv(1, 5'd18, 32'hA8, 1, 5'd15, 32'hB5);
    chk("full_f5_cnt", starve_cnt, 4);
    chk("full_f5_ready", ll_ready, 0);
    chk("full_f5_wregno", wregno, 11);
    chk("full_f5_regval", regval, 32'hB1);
    chk("full_f5_stall", pipe_stall, 1);
    cyc(); drv(1, 5'd18, 32'hA8, 1, 5'd15, 32'hB5);
    chk("full_f6_ready", ll_ready, 1);
    chk("full_f6_cnt", starve_cnt, 0);
    chk("full_f6_wregno", wregno, 18);
    chk("full_f6_stall", pipe_stall, 0);
    chk("full_f6_pend", pend_mask, 32'h0000_2000);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("full_f7_ready", ll_ready, 0);
    chk("full_f7_pend", pend_mask, 32'h0000_A000);
    chk("full_f7_wr", wr_reg, 1);
    chk("full_f7_wregno", wregno, 13);
    chk("full_f7_regval", regval, 32'hB3);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("full_f8_wregno", wregno, 15);
    chk("full_f8_regval", regval, 32'hB5);
    chk("full_f8_pend", pend_mask, 32'h0000_8000);
    chk("full_f8_ready", ll_ready, 1);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("full_f9_wr", wr_reg, 0);
    chk("full_f9_pend", pend_mask, 0);

    // x0 writes are consumed but never enabled
    cyc(); drv(1, 5'd0, 32'h1234, 1, 5'd0, 32'h55);
    chk("x0_pipe_wr", wr_reg, 0);
    chk("x0_pipe_stall", pipe_stall, 0);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("x0_ll_wr", wr_reg, 0);
    chk("x0_ll_pend", pend_mask, 0);
    chk("x0_ll_wregno", wregno, 0);
    cyc(); drv(0, 0, 0, 1, 5'd9, 32'h99);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("x0_popped_wregno", wregno, 9);
    chk("x0_popped_regval", regval, 32'h99);

    // Simultaneous push and pop at depth 1
    cyc(); drv(0, 0, 0, 1, 5'd20, 32'hA20);
    cyc(); drv(0, 0, 0, 1, 5'd21, 32'hA21);
    chk("pp_s1_wregno", wregno, 20);
    chk("pp_s1_regval", regval, 32'hA20);
    chk("pp_s1_ready", ll_ready, 1);
    chk("pp_s1_pend", pend_mask, 32'h0010_0000);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("pp_s2_wregno", wregno, 21);
    chk("pp_s2_regval", regval, 32'hA21);
    chk("pp_s2_pend", pend_mask, 32'h0020_0000);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("pp_s3_wr", wr_reg, 0);
    chk("pp_s3_pend", pend_mask, 0);

    // Reset while full with starve_cnt = 3
    cyc(); drv(1, 5'd1, 32'h1, 1, 5'd2, 32'hC2);
    cyc(); drv(1, 5'd2, 32'h2, 1, 5'd3, 32'hC3);
    cyc(); drv(1, 5'd3, 32'h3, 0, 0, 0);
    cyc(); drv(1, 5'd4, 32'h4, 0, 0, 0);
    cyc(); drv(1, 5'd5, 32'h5, 0, 0, 0);
    chk("rf_cnt", starve_cnt, 3);
    chk("rf_ready", ll_ready, 0);
    chk("rf_pend", pend_mask, 32'hC);
    chk("rf_wregno", wregno, 5);
    cyc(); reset = 1'b1; drv(1, 5'd6, 32'h6, 0, 0, 0);
    chk("rf_rst_wr", wr_reg, 0);
    chk("rf_rst_stall", pipe_stall, 0);
    chk("rf_rst_ready", ll_ready, 0);
    chk("rf_rst_wregno", wregno, 0);
    chk("rf_rst_regval", regval, 0);
    cyc(); reset = 1'b0; drv(0, 0, 0, 0, 0, 0);
    chk("rf_after_cnt", starve_cnt, 0);
    chk("rf_after_pend", pend_mask, 0);
    chk("rf_after_wr", wr_reg, 0);
    chk("rf_after_ready", ll_ready, 1);
    cyc(); drv(0, 0, 0, 0, 0, 0);
    chk("rf_after2_wr", wr_reg, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
